// File: rtl/baggage_pkg.sv
// Shared types and constants for the baggage-drop height acquisition path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package baggage_pkg;

    localparam int NUM_SENSORS = 4;
    localparam int SENSOR_W    = 8;

    // Published value for a sensor that never answered during its slot.
    localparam logic [SENSOR_W-1:0] FAULT_VALUE = 8'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        GAP   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_timeout_timer.sv
// Clear/enable wait counter flagging when a bus request has waited TIMEOUT cycles.
// Latency: expired is decoded from the registered count (valid the cycle count hits TIMEOUT-1).
// Backpressure: none; clr wins over en, the owner stops en once expired is seen.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return count to 0 on the next edge
//   en         : advance count by one on the next edge
//   expired    : count == TIMEOUT-1
module acq_timeout_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sensor_acquire.sv
// Polls four distance sensors over a shared req/ack bus, averages 2^AVG_LOG2 samples each, publishes atomically.
// Latency: valid rises 4*(2N+1) edges after start when every sample is acked in its first REQ cycle.
// Backpressure: a silent sensor holds sens_req for TIMEOUT cycles, then is flagged faulty and skipped.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a run (sampled only when idle)
//   sens_data, sens_ack   : sensor bus response (ack considered only while requesting)
//   sens_sel, sens_req    : sensor bus address and request
//   sensor1..sensor4      : averaged readings of the last completed run (0 if faulty)
//   fault                 : bit k set when sensor k+1 timed out in the last completed run
//   valid                 : one-cycle pulse when sensor1..4 and fault were just updated
//   busy                  : run in progress
module sensor_acquire
    import baggage_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SENSOR_W-1:0]    sens_data,
    input  logic                   sens_ack,
    output logic [1:0]             sens_sel,
    output logic                   sens_req,
    output logic [SENSOR_W-1:0]    sensor1,
    output logic [SENSOR_W-1:0]    sensor2,
    output logic [SENSOR_W-1:0]    sensor3,
    output logic [SENSOR_W-1:0]    sensor4,
    output logic [NUM_SENSORS-1:0] fault,
    output logic                   valid,
    output logic                   busy
);

    localparam int N     = 1 << AVG_LOG2;
    // Sum of N 8-bit samples fits exactly in SENSOR_W+AVG_LOG2 bits.
    localparam int ACC_W = SENSOR_W + AVG_LOG2;
    // Keep the sample counter at least one bit wide when only one sample is taken.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [1:0] LAST_IDX = 2'(NUM_SENSORS - 1);

    acq_state_t state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;

    // Shadow copies collect one run's results; the published copies only
    // change on the edge into DONE so downstream never sees a mixed run.
    logic [SENSOR_W-1:0]    shadow_q [NUM_SENSORS];
    logic [SENSOR_W-1:0]    shadow_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] shadow_fault_q, shadow_fault_d;
    logic [SENSOR_W-1:0]    sensor_q [NUM_SENSORS];
    logic [SENSOR_W-1:0]    sensor_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] fault_q, fault_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    acq_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sample_cnt_d   = sample_cnt_q;
        acc_d          = acc_q;
        shadow_d       = shadow_q;
        shadow_fault_d = shadow_fault_q;
        sensor_d       = sensor_q;
        fault_d        = fault_q;
        timer_clr      = 1'b0;
        timer_en       = 1'b0;

        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (start) begin
                    state_d        = REQ;
                    idx_d          = 2'd0;
                    sample_cnt_d   = '0;
                    acc_d          = '0;
                    shadow_fault_d = '0;
                end
            end

            REQ: begin
                // Ack is checked before the timeout so a response arriving
                // in the very last allowed cycle still counts.
                if (sens_ack) begin
                    acc_d     = acc_q + ACC_W'(sens_data);
                    timer_clr = 1'b1;
                    state_d   = GAP;
                end else if (timer_expired) begin
                    shadow_fault_d[idx_q] = 1'b1;
                    state_d               = STORE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            GAP: begin
                // One idle bus cycle between samples lets the sensor drop ack.
                if (sample_cnt_q == CNT_W'(N - 1)) begin
                    state_d = STORE;
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    state_d      = REQ;
                end
            end

            STORE: begin
                shadow_d[idx_q] = shadow_fault_q[idx_q] ? FAULT_VALUE
                                                        : SENSOR_W'(acc_q >> AVG_LOG2);
                acc_d           = '0;
                sample_cnt_d    = '0;
                timer_clr       = 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Publish from shadow_d so the last sensor's result,
                    // written on this same edge, is included.
                    sensor_d = shadow_d;
                    fault_d  = shadow_fault_q;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = REQ;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= 2'd0;
            sample_cnt_q   <= '0;
            acc_q          <= '0;
            shadow_fault_q <= '0;
            fault_q        <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                shadow_q[i] <= '0;
                sensor_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sample_cnt_q   <= sample_cnt_d;
            acc_q          <= acc_d;
            shadow_fault_q <= shadow_fault_d;
            fault_q        <= fault_d;
            shadow_q       <= shadow_d;
            sensor_q       <= sensor_d;
        end
    end

    assign sens_req = (state_q == REQ);
    assign sens_sel = idx_q;
    assign busy     = (state_q != IDLE);
    assign valid    = (state_q == DONE);
    assign sensor1  = sensor_q[0];
    assign sensor2  = sensor_q[1];
    assign sensor3  = sensor_q[2];
    assign sensor4  = sensor_q[3];
    assign fault    = fault_q;

endmodule

// File: tb/tb_sensor_acquire.sv
// Self-checking bench for sensor_acquire: a sensor-bus responder with per-sensor
// ack delay and sample tables, checked against an arithmetic model of each run.
module tb_sensor_acquire;

    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 16;
    localparam int N        = 1 << AVG_LOG2;
    localparam int NEVER    = 1000;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] sens_data;
    logic       sens_ack;
    logic [1:0] sens_sel;
    logic       sens_req;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    logic       valid;
    logic       busy;

    sensor_acquire #(
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sens_data (sens_data),
        .sens_ack  (sens_ack),
        .sens_sel  (sens_sel),
        .sens_req  (sens_req),
        .sensor1   (sensor1),
        .sensor2   (sensor2),
        .sensor3   (sensor3),
        .sensor4   (sensor4),
        .fault     (fault),
        .valid     (valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Responder configuration: ack delay in REQ cycles (>= TIMEOUT means fault).
    int         delay_cfg [4];
    logic [7:0] data_tab  [4][16];
    int         samp_idx  [4];

    // Model results.
    logic [7:0] exp_sens [4];
    logic [7:0] prev_sens [4];
    logic [3:0] exp_fault;
    logic [3:0] prev_fault;
    int         exp_lat;
    int         exp_maxreq;

    // Observations from the last run.
    int lat_o;
    int maxreq_o;
    bit gotv_o;
    bit oneshot_o;

    // Sensor bus responder: ack after delay_cfg[sel] waiting cycles, random
    // noise on ack/data whenever no request is pending.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        sens_ack  = 1'b0;
        sens_data = 8'd0;
        forever begin
            @(negedge clk);
            if (sens_req) begin
                if (wait_cnt == delay_cfg[sens_sel]) begin
                    sens_ack  = 1'b1;
                    sens_data = data_tab[sens_sel][samp_idx[sens_sel] % 16];
                    samp_idx[sens_sel]++;
                end else begin
                    sens_ack  = 1'b0;
                    sens_data = 8'($urandom);
                end
                wait_cnt++;
            end else begin
                sens_ack  = 1'($urandom_range(0, 1));
                sens_data = 8'($urandom);
                wait_cnt  = 0;
            end
        end
    end

    function automatic logic [7:0] obs_sens(input int k);
        case (k)
            0:       return sensor1;
            1:       return sensor2;
            2:       return sensor3;
            default: return sensor4;
        endcase
    endfunction

    // Reference: each sensor either averages its N samples (integer division)
    // or is faulty; a good sensor costs N*(delay+REQ-exit+GAP)+STORE cycles,
    // a silent one TIMEOUT request cycles plus STORE.
    task automatic model_run();
        int sum;
        int mr;
        exp_lat    = 0;
        exp_maxreq = 0;
        exp_fault  = '0;
        for (int k = 0; k < 4; k++) begin
            if (delay_cfg[k] >= TIMEOUT) begin
                exp_fault[k] = 1'b1;
                exp_sens[k]  = 8'd0;
                exp_lat     += TIMEOUT + 1;
                mr           = TIMEOUT;
            end else begin
                sum = 0;
                for (int s = 0; s < N; s++) sum += data_tab[k][s];
                exp_sens[k] = 8'(sum / N);
                exp_lat    += N * (delay_cfg[k] + 2) + 1;
                mr          = delay_cfg[k] + 1;
            end
            if (mr > exp_maxreq) exp_maxreq = mr;
        end
    endtask

    task automatic run_acq();
        int run;
        for (int k = 0; k < 4; k++) samp_idx[k] = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        run      = sens_req ? 1 : 0;
        maxreq_o = run;
        lat_o    = 0;
        gotv_o   = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (sens_req) begin
                run++;
                if (run > maxreq_o) maxreq_o = run;
            end else begin
                run = 0;
            end
            if (valid) begin
                lat_o  = c;
                gotv_o = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        oneshot_o = !valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) delay_cfg[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({sensor1, sensor2, sensor3, sensor4} !== 32'd0) begin n_fail++; $display("FAIL reset_sensors got %h want 0", {sensor1, sensor2, sensor3, sensor4}); end
        n_cmp++; if ({fault, valid, busy, sens_req, sens_sel} !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl got fault=%b valid=%b busy=%b req=%b sel=%0d want all 0", fault, valid, busy, sens_req, sens_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, sens_req, valid} !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset got busy=%b req=%b valid=%b want 000", busy, sens_req, valid); end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 4; k++) begin
            delay_cfg[k] = 0;
            for (int s = 0; s < 16; s++) data_tab[k][s] = 8'(10 + s);
        end
        model_run();
        run_acq();
        n_cmp++; if (!gotv_o || lat_o != 36) begin n_fail++; $display("FAIL basic_latency got %0d (valid seen %0d) want 36", lat_o, gotv_o); end
        n_cmp++; if (!oneshot_o) begin n_fail++; $display("FAIL basic_valid_width got valid still 1 want single-cycle pulse"); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (obs_sens(k) !== 8'd11) begin n_fail++; $display("FAIL basic_sensor%0d got %0d want 11", k + 1, obs_sens(k)); end
        end
        n_cmp++; if (fault !== 4'b0000) begin n_fail++; $display("FAIL basic_fault got %b want 0000", fault); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_sensor3_fault();
        for (int k = 0; k < 4; k++) begin
            delay_cfg[k] = (k == 2) ? NEVER : 0;
            for (int s = 0; s < 16; s++) data_tab[k][s] = 8'($urandom);
        end
        model_run();
        run_acq();
        n_cmp++; if (maxreq_o != TIMEOUT) begin n_fail++; $display("FAIL s3_req_hold got %0d want %0d", maxreq_o, TIMEOUT); end
        n_cmp++; if (!gotv_o || lat_o != exp_lat) begin n_fail++; $display("FAIL s3_latency got %0d want %0d", lat_o, exp_lat); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (obs_sens(k) !== exp_sens[k]) begin n_fail++; $display("FAIL s3_sensor%0d got %0d want %0d", k + 1, obs_sens(k), exp_sens[k]); end
        end
        n_cmp++; if (fault !== 4'b0100) begin n_fail++; $display("FAIL s3_fault got %b want 0100", fault); end
    endtask

    task automatic test_timeout_boundary();
        for (int d = TIMEOUT - 1; d <= TIMEOUT; d++) begin
            for (int k = 0; k < 4; k++) begin
                delay_cfg[k] = d;
                for (int s = 0; s < 16; s++) data_tab[k][s] = 8'($urandom);
            end
            model_run();
            run_acq();
            n_cmp++; if (!gotv_o || lat_o != exp_lat) begin n_fail++; $display("FAIL bound%0d_latency got %0d want %0d", d, lat_o, exp_lat); end
            n_cmp++; if (fault !== exp_fault) begin n_fail++; $display("FAIL bound%0d_fault got %b want %b", d, fault, exp_fault); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (obs_sens(k) !== exp_sens[k]) begin n_fail++; $display("FAIL bound%0d_sensor%0d got %0d want %0d", d, k + 1, obs_sens(k), exp_sens[k]); end
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] trunc_pat [4];
        trunc_pat[0] = 8'd3; trunc_pat[1] = 8'd4; trunc_pat[2] = 8'd4; trunc_pat[3] = 8'd4;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                delay_cfg[k] = $urandom_range(0, 2);
                for (int s = 0; s < 16; s++) data_tab[k][s] = (p == 0) ? 8'd255 : trunc_pat[s % 4];
            end
            model_run();
            run_acq();
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (obs_sens(k) !== ((p == 0) ? 8'd255 : 8'd3)) begin n_fail++; $display("FAIL extreme%0d_sensor%0d got %0d want %0d", p, k + 1, obs_sens(k), (p == 0) ? 255 : 3); end
            end
            n_cmp++; if (!gotv_o || lat_o != exp_lat || fault !== 4'b0000) begin n_fail++; $display("FAIL extreme%0d_run got lat=%0d fault=%b want lat=%0d fault=0000", p, lat_o, fault, exp_lat); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                delay_cfg[k] = ($urandom_range(0, 4) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                                           : int'($urandom_range(0, 5));
                for (int s = 0; s < 16; s++) data_tab[k][s] = 8'($urandom);
            end
            model_run();
            run_acq();
            n_cmp++; if (!gotv_o || lat_o != exp_lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", r, lat_o, exp_lat); end
            n_cmp++; if (maxreq_o != exp_maxreq) begin n_fail++; $display("FAIL rand%0d_req_hold got %0d want %0d", r, maxreq_o, exp_maxreq); end
            n_cmp++; if (fault !== exp_fault) begin n_fail++; $display("FAIL rand%0d_fault got %b want %b", r, fault, exp_fault); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (obs_sens(k) !== exp_sens[k]) begin n_fail++; $display("FAIL rand%0d_sensor%0d got %0d want %0d", r, k + 1, obs_sens(k), exp_sens[k]); end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        bit rebusy;
        prev_sens  = exp_sens;
        prev_fault = exp_fault;
        for (int k = 0; k < 4; k++) begin
            delay_cfg[k] = 1;
            for (int s = 0; s < 16; s++) data_tab[k][s] = 8'($urandom);
            samp_idx[k] = 0;
        end
        model_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        gotv_o = 1'b0;
        lat_o  = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            start = (c == 10);
            if (c == 20) begin
                for (int k = 0; k < 4; k++) begin
                    n_cmp++; if (obs_sens(k) !== prev_sens[k]) begin n_fail++; $display("FAIL busy_hold_sensor%0d got %0d want %0d", k + 1, obs_sens(k), prev_sens[k]); end
                end
                n_cmp++; if (fault !== prev_fault) begin n_fail++; $display("FAIL busy_hold_fault got %b want %b", fault, prev_fault); end
            end
            if (valid) begin
                lat_o  = c;
                gotv_o = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_cmp++; if (!gotv_o || lat_o != exp_lat) begin n_fail++; $display("FAIL busy_latency got %0d want %0d", lat_o, exp_lat); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (obs_sens(k) !== exp_sens[k]) begin n_fail++; $display("FAIL busy_sensor%0d got %0d want %0d", k + 1, obs_sens(k), exp_sens[k]); end
        end
        pulses = 0;
        rebusy = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
            if (busy) rebusy = 1'b1;
        end
        n_cmp++; if (pulses != 0 || rebusy) begin n_fail++; $display("FAIL busy_no_restart got extra pulses=%0d busy=%0d want 0 0", pulses, rebusy); end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        for (int k = 0; k < 4; k++) begin
            delay_cfg[k] = 0;
            for (int s = 0; s < 16; s++) data_tab[k][s] = 8'($urandom);
            samp_idx[k] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (sens_req && sens_sel == 2'd1 && samp_idx[1] == 2) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL midrst_reach got no sensor2/sample2 request want one within 500 cycles"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sensor1, sensor2, sensor3, sensor4} !== 32'd0) begin n_fail++; $display("FAIL midrst_sensors got %h want 0", {sensor1, sensor2, sensor3, sensor4}); end
        n_cmp++; if ({fault, valid, busy, sens_req, sens_sel} !== 9'd0) begin n_fail++; $display("FAIL midrst_ctrl got fault=%b valid=%b busy=%b req=%b sel=%0d want all 0", fault, valid, busy, sens_req, sens_sel); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_run();
        run_acq();
        n_cmp++; if (!gotv_o || lat_o != exp_lat) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", lat_o, exp_lat); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (obs_sens(k) !== exp_sens[k]) begin n_fail++; $display("FAIL midrst_sensor%0d got %0d want %0d", k + 1, obs_sens(k), exp_sens[k]); end
        end
        n_cmp++; if (fault !== 4'b0000) begin n_fail++; $display("FAIL midrst_fault got %b want 0000", fault); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) samp_idx[k] = 0;
        test_reset();
        test_basic();
        test_sensor3_fault();
        test_timeout_boundary();
        test_extremes();
        test_random();
        test_start_while_busy();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
